// File: rtl/countdown_pkg.sv
// Shared definitions for the MM:SS BCD countdown timer.
//   state_t        : FSM state encoding (idle, running, paused, expired)
//   BCD_MAX_UNITS  : highest value of a units digit (m0, s0)
//   BCD_MAX_TENS   : highest value of a tens digit (m1, s1)
//   bcd_clamp()    : saturate a preset nibble to a digit's maximum
package countdown_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] value, input logic [3:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown borrow chain.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (digit -> 0)
//   load, value : synchronous parallel load of an already-clamped digit
//   dec_in      : decrement request from the less significant stage
//   digit       : current registered digit value
//   borrow_out  : decrement request to the next stage (digit is 0 and dec_in)
module bcd_down_digit
    import countdown_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_MAX_UNITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] value,
    input  logic       dec_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    assign borrow_out = dec_in && (digit == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= value;
        end else if (dec_in) begin
            digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer feeding a four-digit seven-segment driver.
// Ports:
//   clk, rst              : 100 MHz clock, asynchronous active-high reset
//   load, start, stop     : single-cycle command pulses (priority load > stop > start)
//   preset_m1..preset_s0  : BCD preset digits, clamped to 59:59 on load
//   disp3..disp0          : current count, m1 m0 s1 s0
//   running               : registered, high while counting
//   expired               : one-cycle pulse when the count reaches 00:00
//   alarm                 : steady high in the expired state, or a 2 Hz blink when
//                           ALARM_BLINK_EN is defined
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] preset_m1,
    input  logic [3:0] preset_m0,
    input  logic [3:0] preset_s1,
    input  logic [3:0] preset_s0,
    output logic [3:0] disp3,
    output logic [3:0] disp2,
    output logic [3:0] disp1,
    output logic [3:0] disp0,
    output logic       running,
    output logic       expired,
    output logic       alarm
);

    localparam int unsigned PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    state_t             state;
    state_t             state_next;
    logic [PRESC_W-1:0] presc;
    logic               load_ok;
    logic               stop_ok;
    logic               start_ok;
    logic               tick;
    logic               count_zero;
    logic               count_one;
    logic               expired_next;
    logic               borrow0;
    logic               borrow1;
    logic               borrow2;
    logic               borrow3;

    // Command qualification; lower-priority commands are masked by accepted higher ones.
    assign load_ok  = load && (state != StRun);
    assign stop_ok  = stop && (state == StRun);
    assign start_ok = start && !load_ok && !stop && ((state == StIdle) || (state == StPause));

    // A stop on the terminal prescaler cycle wins: the tick is suppressed and both hold.
    assign tick = (state == StRun) && !stop && (presc == PRESC_LAST);

    assign count_zero = (disp3 == 4'd0) && (disp2 == 4'd0) && (disp1 == 4'd0) && (disp0 == 4'd0);
    // 00:01 is the only value whose decrement gives 00:00.
    assign count_one  = (disp3 == 4'd0) && (disp2 == 4'd0) && (disp1 == 4'd0) && (disp0 == 4'd1);

    bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_s0 (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ok),
        .value      (bcd_clamp(preset_s0, BCD_MAX_UNITS)),
        .dec_in     (tick),
        .digit      (disp0),
        .borrow_out (borrow0)
    );

    bcd_down_digit #(.MAX(BCD_MAX_TENS)) u_s1 (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ok),
        .value      (bcd_clamp(preset_s1, BCD_MAX_TENS)),
        .dec_in     (borrow0),
        .digit      (disp1),
        .borrow_out (borrow1)
    );

    bcd_down_digit #(.MAX(BCD_MAX_UNITS)) u_m0 (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ok),
        .value      (bcd_clamp(preset_m0, BCD_MAX_UNITS)),
        .dec_in     (borrow1),
        .digit      (disp2),
        .borrow_out (borrow2)
    );

    // m1 never borrows: ticks stop at 00:00, so its borrow_out is never asserted.
    bcd_down_digit #(.MAX(BCD_MAX_TENS)) u_m1 (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ok),
        .value      (bcd_clamp(preset_m1, BCD_MAX_TENS)),
        .dec_in     (borrow2),
        .digit      (disp3),
        .borrow_out (borrow3)
    );

    always_comb begin
        state_next   = state;
        expired_next = 1'b0;
        if (load_ok) begin
            state_next = StIdle;
        end else if (stop_ok) begin
            state_next = StPause;
        end else if (start_ok) begin
            state_next   = count_zero ? StDone : StRun;
            expired_next = count_zero;
        end else if (tick && count_one) begin
            state_next   = StDone;
            expired_next = 1'b1;
        end
    end

    // Prescaler only advances in RUN; PAUSE keeps the phase for resume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (load_ok) begin
            presc <= '0;
        end else if ((state == StRun) && !stop) begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            running <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == StRun);
            expired <= expired_next;
        end
    end

`ifdef ALARM_BLINK_EN
    localparam int unsigned BLINK_PERIOD = TICKS_PER_SEC / 4;
    localparam int unsigned BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);

    logic [BLINK_W-1:0] blink_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            alarm     <= 1'b0;
        end else if (state_next != StDone) begin
            blink_cnt <= '0;
            alarm     <= 1'b0;
        end else if (state != StDone) begin
            // Entering DONE: blink starts in the lit phase.
            blink_cnt <= '0;
            alarm     <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            alarm     <= ~alarm;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm <= 1'b0;
        end else begin
            alarm <= (state_next == StDone);
        end
    end
`endif

endmodule
